hms_countdown: RTL and testbench
================================

# hms_countdown

BCD minutes/seconds countdown timer. It is the down-counting counterpart of the team's up-counting BCD hour timer, and shares its digit-per-nibble output format so both drive the same display path. Software or a front panel loads an MM:SS value through a valid/ready handshake, then starts, pauses, resumes or clears the count. A one-cycle `done` pulse marks expiry.

## Interface
- `CLK_DIV`, default 50_000_000: clk cycles per 1 s tick; legal range ≥2.
- `clk`  in  1  system clock, rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `load_valid`  in  1  load request.
- `load_ready`  out  1  high in IDLE and DONE only.
- `load_min`  in  8  BCD minutes {tens,units}.
- `load_sec`  in  8  BCD seconds {tens,units}.
- `start`  in  1  level-sampled start/resume.
- `pause`  in  1  level-sampled pause.
- `clear`  in  1  synchronous abort to IDLE, value zeroed.
- `min_tens`, `min_units`, `sec_tens`, `sec_units`  out  4 each  current BCD value.
- `running`  out  1  high in RUN.
- `done`  out  1  one-cycle expiry pulse.
- `load_err`  out  1  one-cycle pulse on a rejected load.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Reset and `clear` put the block in IDLE with all digits 0, prescaler 0, and `running`/`done`/`load_err` = 0.
- Command priority per cycle: clear > load > start > pause.
- **Load:**
  - Accepted when `load_valid && load_ready`.
  - Valid only if every units digit ≤9 and every tens digit ≤5.
  - Valid load: digits take the new value; state becomes IDLE (also from DONE).
  - Invalid load: `load_err` pulses, digits and state are unchanged.
  - Load requests in RUN/PAUSE are ignored, with no `load_err`.
- **IDLE:** `start` with a nonzero value goes to RUN with prescaler 0. `start` with value 00:00 is ignored.
- **RUN:**
  - Prescaler counts 0..CLK_DIV-1; at CLK_DIV-1 it wraps to 0 and decrements the value by one second.
  - `pause` goes to PAUSE; `start` is ignored.
- **PAUSE:** prescaler and digits are frozen, not cleared. `start` returns to RUN and resumes from the held prescaler count. `pause` is ignored.
- **Decrement, borrow chain:**
  - sec_units 0→9 borrows from sec_tens.
  - sec_tens 0→5 borrows from min_units.
  - min_units 0→9 borrows from min_tens.
  - Example: 10:00 → 09:59.
- **Expiry:** the tick that produces 00:00 moves to DONE. `done` is high in that same registered cycle only; `running` is low from that cycle on.
- **DONE:** digits hold 00:00; `start`/`pause` are ignored; a valid load or `clear` leaves DONE.

## Timing
- All outputs are registered.
- Load accepted at edge N: digits show the new value after edge N; `load_err` is high for the cycle after edge N.
- `start` sampled at edge N in IDLE: `running` is high after N. The first decrement is visible after edge N+CLK_DIV, then one every CLK_DIV cycles.
- A loaded value of S seconds expires exactly S·CLK_DIV cycles after the start edge, excluding paused cycles.
- `rstn` is asynchronous: on assertion, outputs go to reset values immediately mid-count. Deassertion is synchronized externally. After release there is no `done`, even if a count was in progress.
- `clear` in the expiry cycle wins: IDLE, and no `done`.

## Structure
- Package `hms_pkg`: state enum, and the BCD limit constants `UNITS_MAX=9` and `TENS_MAX=5`.
- Sub-module `bcd_down_digit`:
  - Parameter MAX.
  - Ports: clk, rstn, load, load_val, dec, borrow_out.
  - It decrements when dec=1 and wraps 0→MAX, asserting borrow_out combinationally when value==0 && dec.
  - Instantiate four of them.
- The top level holds the FSM, prescaler, load validation and handshake.

## Test plan
All scenarios use CLK_DIV=4.
1. **Basic expiry:** load 00:03, start → 00:02 at +4, 00:01 at +8, 00:00 at +12. `done` is high exactly one cycle at +12; `running` falls; `load_ready` rises.
2. **Borrow chain:** load 10:00, start → 09:59 after 4 cycles. Load 01:00 → 00:59.
3. **Invalid loads:** load_sec=8'h60 and load_min=8'h0A each pulse `load_err` once; digits remain at the previous value; state stays IDLE.
4. **Pause/resume:** load 00:05, start, pause at +6 (value 00:04, prescaler 2), hold pause 20 cycles with no change, start → 00:03 two cycles after resume.
5. **Abort:**
   - `clear` during RUN at 00:02 → 00:00 and IDLE, no `done`.
   - Async `rstn` low mid-RUN → all outputs 0 before the next clk edge.
6. **Handshake and ignored commands:**
   - A load request during RUN keeps `load_ready`=0, leaves the value untouched, and gives no `load_err`.
   - `start` with 00:00 in IDLE keeps `running`=0.
   - A load in DONE of 00:02 is accepted → IDLE.

Source files
------------

// File: rtl/hms_pkg.sv
// Shared types and BCD limits for the MM:SS countdown timer.
package hms_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] UNITS_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;

  // True when a {tens,units} byte is a legal minutes/seconds field.
  function automatic logic bcd_pair_ok(input logic [7:0] v);
    return (v[7:4] <= TENS_MAX) && (v[3:0] <= UNITS_MAX);
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the countdown: loadable, decrements with wrap 0->MAX and borrow out.
module bcd_down_digit
  import hms_pkg::*;
#(
  parameter logic [3:0] MAX = UNITS_MAX
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] value,
  output logic       borrow_out
);

  logic [3:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (load) begin
      val_d = load_val;
    end else if (dec) begin
      val_d = (val_q == 4'd0) ? MAX : val_q - 4'd1;
    end
  end

  assign borrow_out = dec && (val_q == 4'd0);
  assign value      = val_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      val_q <= 4'd0;
    end else begin
      val_q <= val_d;
    end
  end

endmodule

// File: rtl/hms_countdown.sv
// BCD MM:SS countdown timer: load handshake, run/pause/clear control, 1 s prescaler
// and a one-cycle done pulse on expiry.
module hms_countdown
  import hms_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       running,
  output logic       done,
  output logic       load_err
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          dig_load;
  logic [15:0]   dig_val;
  logic          tick;
  logic          b_su, b_st, b_mu, borrow_unused;
  logic          accept, load_ok, value_zero, last_sec;

  assign load_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign running    = (state_q == ST_RUN);
  assign done       = done_q;
  assign load_err   = err_q;

  assign accept     = load_valid && load_ready;
  assign load_ok    = bcd_pair_ok(load_min) && bcd_pair_ok(load_sec);
  assign value_zero = ({min_tens, min_units, sec_tens, sec_units} == 16'h0000);
  assign last_sec   = ({min_tens, min_units, sec_tens, sec_units} == 16'h0001);

  // Priority: clear > load > start > pause; tick only fires when no command overrides it.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    dig_load = 1'b0;
    dig_val  = 16'h0000;
    tick     = 1'b0;
    if (clear) begin
      state_d  = ST_IDLE;
      presc_d  = '0;
      dig_load = 1'b1;
    end else if (accept) begin
      if (load_ok) begin
        state_d  = ST_IDLE;
        presc_d  = '0;
        dig_load = 1'b1;
        dig_val  = {load_min, load_sec};
      end else begin
        err_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && !value_zero) begin
            state_d = ST_RUN;
            presc_d = '0;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick    = 1'b1;
            if (last_sec) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (start) state_d = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  bcd_down_digit #(.MAX(UNITS_MAX)) u_sec_units (
    .clk(clk), .rstn(rstn), .load(dig_load), .load_val(dig_val[3:0]),
    .dec(tick), .value(sec_units), .borrow_out(b_su)
  );

  bcd_down_digit #(.MAX(TENS_MAX)) u_sec_tens (
    .clk(clk), .rstn(rstn), .load(dig_load), .load_val(dig_val[7:4]),
    .dec(b_su), .value(sec_tens), .borrow_out(b_st)
  );

  bcd_down_digit #(.MAX(UNITS_MAX)) u_min_units (
    .clk(clk), .rstn(rstn), .load(dig_load), .load_val(dig_val[11:8]),
    .dec(b_st), .value(min_units), .borrow_out(b_mu)
  );

  // Minutes-tens borrow would mean underflow past 00:00, which the FSM never allows.
  bcd_down_digit #(.MAX(TENS_MAX)) u_min_tens (
    .clk(clk), .rstn(rstn), .load(dig_load), .load_val(dig_val[15:12]),
    .dec(b_mu), .value(min_tens), .borrow_out(borrow_unused)
  );

endmodule

// File: tb/tb_hms_countdown.sv
// Directed bench for hms_countdown with CLK_DIV=4 and a queue-based scoreboard.
module tb_hms_countdown;

  logic       clk = 1'b0;
  logic       rstn;
  logic       load_valid, load_ready;
  logic [7:0] load_min, load_sec;
  logic       start, pause, clear;
  logic [3:0] min_tens, min_units, sec_tens, sec_units;
  logic       running, done, load_err;

  typedef struct {
    string       tag;
    logic [19:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  hms_countdown #(.CLK_DIV(4)) dut (
    .clk(clk), .rstn(rstn),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_min(load_min), .load_sec(load_sec),
    .start(start), .pause(pause), .clear(clear),
    .min_tens(min_tens), .min_units(min_units),
    .sec_tens(sec_tens), .sec_units(sec_units),
    .running(running), .done(done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected: {MMSS digits, load_ready, running, done, load_err}
  task automatic push(input string tag, input logic [15:0] d,
                      input logic rdy, input logic run, input logic dn, input logic err);
    exp_t e;
    e.tag = tag;
    e.exp = {d, rdy, run, dn, err};
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t        e;
    logic [19:0] o;
    o = {min_tens, min_units, sec_tens, sec_units, load_ready, running, done, load_err};
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h", o);
    end else begin
      e = sb.pop_front();
      assert (o === e.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic drive_load(input logic [7:0] m, input logic [7:0] s);
    load_valid = 1'b1;
    load_min   = m;
    load_sec   = s;
  endtask

  initial begin
    rstn = 1'b0; load_valid = 1'b0; load_min = 8'h00; load_sec = 8'h00;
    start = 1'b0; pause = 1'b0; clear = 1'b0;
    #2;
    push("reset", 16'h0000, 1, 0, 0, 0); check_pop();
    cyc();
    rstn = 1'b1;

    // Basic expiry 00:03
    drive_load(8'h00, 8'h03);
    push("load_0003", 16'h0003, 1, 0, 0, 0); cyc(); check_pop();
    load_valid = 1'b0;
    start = 1'b1;
    push("start_0003", 16'h0003, 0, 1, 0, 0); cyc(); check_pop();
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      push($sformatf("expire_k%0d", k), 16'(3 - k / 4), k == 12, k < 12, k == 12, 1'b0);
      cyc(); check_pop();
    end
    push("done_pulse_end", 16'h0000, 1, 0, 0, 0); cyc(); check_pop();

    // Load in DONE, then start with 00:00 ignored
    drive_load(8'h00, 8'h02);
    push("load_in_done", 16'h0002, 1, 0, 0, 0); cyc(); check_pop();
    load_valid = 1'b0;
    clear = 1'b1;
    push("clear_idle", 16'h0000, 1, 0, 0, 0); cyc(); check_pop();
    clear = 1'b0;
    start = 1'b1;
    push("start_zero_ignored", 16'h0000, 1, 0, 0, 0); cyc(); check_pop();
    start = 1'b0;

    // Borrow chain
    drive_load(8'h10, 8'h00);
    push("load_1000", 16'h1000, 1, 0, 0, 0); cyc(); check_pop();
    load_valid = 1'b0;
    start = 1'b1;
    push("start_1000", 16'h1000, 0, 1, 0, 0); cyc(); check_pop();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      push($sformatf("borrow_1000_k%0d", k), (k == 4) ? 16'h0959 : 16'h1000, 0, 1, 0, 0);
      cyc(); check_pop();
    end
    clear = 1'b1; cyc(); clear = 1'b0;
    drive_load(8'h01, 8'h00); cyc(); load_valid = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    repeat (3) cyc();
    push("borrow_0100", 16'h0059, 0, 1, 0, 0); cyc(); check_pop();
    clear = 1'b1; cyc(); clear = 1'b0;

    // Invalid loads
    drive_load(8'h12, 8'h34);
    push("load_1234", 16'h1234, 1, 0, 0, 0); cyc(); check_pop();
    drive_load(8'h00, 8'h60);
    push("bad_sec", 16'h1234, 1, 0, 0, 1); cyc(); check_pop();
    load_valid = 1'b0;
    push("bad_sec_end", 16'h1234, 1, 0, 0, 0); cyc(); check_pop();
    drive_load(8'h0A, 8'h00);
    push("bad_min", 16'h1234, 1, 0, 0, 1); cyc(); check_pop();
    load_valid = 1'b0;
    push("bad_min_end", 16'h1234, 1, 0, 0, 0); cyc(); check_pop();
    clear = 1'b1; cyc(); clear = 1'b0;

    // Pause / resume
    drive_load(8'h00, 8'h05); cyc(); load_valid = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    repeat (5) cyc();
    push("run_plus6", 16'h0004, 0, 1, 0, 0); cyc(); check_pop();
    pause = 1'b1;
    push("pause_enter", 16'h0004, 0, 0, 0, 0); cyc(); check_pop();
    for (int k = 0; k < 20; k++) begin
      push($sformatf("pause_hold_%0d", k), 16'h0004, 0, 0, 0, 0); cyc(); check_pop();
    end
    pause = 1'b0;
    start = 1'b1;
    push("resume", 16'h0004, 0, 1, 0, 0); cyc(); check_pop();
    start = 1'b0;
    push("resume_p1", 16'h0004, 0, 1, 0, 0); cyc(); check_pop();
    push("resume_dec", 16'h0003, 0, 1, 0, 0); cyc(); check_pop();

    // Load during RUN ignored, then clear at 00:02
    drive_load(8'h00, 8'h59);
    push("load_in_run", 16'h0003, 0, 1, 0, 0); cyc(); check_pop();
    load_valid = 1'b0;
    repeat (2) cyc();
    push("run_0002", 16'h0002, 0, 1, 0, 0); cyc(); check_pop();
    clear = 1'b1;
    push("clear_at_0002", 16'h0000, 1, 0, 0, 0); cyc(); check_pop();
    clear = 1'b0;
    push("no_done_after_clear", 16'h0000, 1, 0, 0, 0); cyc(); check_pop();

    // Clear in the expiry cycle wins
    drive_load(8'h00, 8'h01); cyc(); load_valid = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    repeat (3) cyc();
    clear = 1'b1;
    push("clear_expiry", 16'h0000, 1, 0, 0, 0); cyc(); check_pop();
    clear = 1'b0;
    push("clear_expiry_after", 16'h0000, 1, 0, 0, 0); cyc(); check_pop();

    // Asynchronous reset mid-count
    drive_load(8'h00, 8'h09); cyc(); load_valid = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    repeat (5) cyc();
    push("pre_reset", 16'h0008, 0, 1, 0, 0); check_pop();
    #2 rstn = 1'b0;
    #1;
    push("async_reset", 16'h0000, 1, 0, 0, 0); check_pop();
    #1 rstn = 1'b1;
    push("post_reset", 16'h0000, 1, 0, 0, 0); cyc(); check_pop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
